// File: rtl/cpg_pkg.sv
// cpg_pkg: shared types and constants for the crop_gaussian block
// Holds the control FSM state enum, result channel indices, accumulator and
// counter widths, and the crop-origin clamp helper.
package cpg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COORD,
        S_STREAM,
        S_OUTPUT,
        S_DONE
    } state_t;

    localparam int OUT_AMP = 0;
    localparam int OUT_ROW = 1;
    localparam int OUT_COL = 2;
    localparam int OUT_SUM = 3;
    localparam int OUT_MIN = 4;
    localparam int NUM_OUT = 5;
    localparam int ACC_W   = 32;
    localparam int CNT_W   = 16;

    // Keeps the crop window inside the frame: origin never exceeds frame size minus window size.
    function automatic logic [CNT_W-1:0] clamp_origin(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/crop_gaussian_if.sv
// crop_gaussian_if: one AXI-Stream channel (tdata/tvalid/tready)
// Ports: tdata [W-1:0], tvalid, tready; master drives tdata/tvalid, slave drives tready.
interface crop_gaussian_if #(
    parameter int W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/cpg_window_counter.sv
// cpg_window_counter: raster row/col tracking and crop-window membership
// Ports: ap_clk, ap_rst_n (sync, active-high), clr (restart at pixel 0),
//        adv (one pixel accepted), y1/x1 (clamped window origin),
//        last (current pixel is the final one of the frame),
//        in_win (current pixel lies in the window), rel_row/rel_col (window-relative indices).
module cpg_window_counter
    import cpg_pkg::*;
#(
    parameter int IN_ROWS  = 100,
    parameter int IN_COLS  = 160,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [CNT_W-1:0] y1,
    input  logic [CNT_W-1:0] x1,
    output logic             last,
    output logic             in_win,
    output logic [CNT_W-1:0] rel_row,
    output logic [CNT_W-1:0] rel_col
);
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             row_end;

    assign row_end = col == CNT_W'(IN_COLS - 1);
    assign last    = row_end && row == CNT_W'(IN_ROWS - 1);
    assign in_win  = row >= y1 && row < y1 + CNT_W'(OUT_ROWS) && col >= x1 && col < x1 + CNT_W'(OUT_COLS);
    assign rel_row = row - y1;
    assign rel_col = col - x1;

    always_ff @(posedge ap_clk) begin
        if (ap_rst_n || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            col <= row_end ? '0 : col + 1'b1;
            row <= row_end ? row + 1'b1 : row;
        end
    end
endmodule

// File: rtl/crop_gaussian.sv
// crop_gaussian: crops a raster frame and emits Gaussian-spot statistics of the window
// Ports: ap_clk; ap_rst_n (sync, active-high reset); ap_start/ap_done/ap_ready/ap_idle block control;
//        img_input (pixel stream), crop_Y1/crop_X1 (window origin) as stream slaves;
//        cnn_output_0..4 (max, max row, max col, shifted sum, min) as stream masters.
// Build option: CPG_SUM_SAT_EN saturates the shifted sum to the pixel range; otherwise it wraps.
module crop_gaussian
    import cpg_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int IN_ROWS          = 100,
    parameter int IN_COLS          = 160,
    parameter int OUT_ROWS         = 48,
    parameter int OUT_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int SUM_SHIFT        = 11
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic ap_start,
    output logic ap_done,
    output logic ap_ready,
    output logic ap_idle,
    crop_gaussian_if.slave  img_input,
    crop_gaussian_if.slave  crop_Y1,
    crop_gaussian_if.slave  crop_X1,
    crop_gaussian_if.master cnn_output_0,
    crop_gaussian_if.master cnn_output_1,
    crop_gaussian_if.master cnn_output_2,
    crop_gaussian_if.master cnn_output_3,
    crop_gaussian_if.master cnn_output_4
);
    localparam int W = PIXEL_BIT_WIDTH;
    localparam logic signed [W-1:0]     PIX_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]     PIX_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_HI  = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO  = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    state_t state, state_n;
    logic                    y1_ok, x1_ok;
    logic [CNT_W-1:0]        y1_q, x1_q;
    logic                    y1_fire, x1_fire, pix_fire, frame_end;
    logic                    last, in_win;
    logic [CNT_W-1:0]        rel_row, rel_col;
    logic signed [W-1:0]     pix;
    logic signed [W-1:0]     max_q, min_q, max_n, min_n;
    logic [CNT_W-1:0]        max_row_q, max_col_q, max_row_n, max_col_n;
    logic signed [ACC_W-1:0] sum_q, sum_n, sum_sh;
    logic [W-1:0]            sum_out;
    logic                    take_max, take_min, upd;
    logic [NUM_OUT-1:0]      out_valid, out_ready, out_fire;
    logic [W-1:0]            out_data [NUM_OUT];

    assign crop_Y1.tready   = state == S_COORD && !y1_ok;
    assign crop_X1.tready   = state == S_COORD && !x1_ok;
    assign img_input.tready = state == S_STREAM;
    assign y1_fire   = crop_Y1.tvalid && crop_Y1.tready;
    assign x1_fire   = crop_X1.tvalid && crop_X1.tready;
    assign pix_fire  = img_input.tvalid && img_input.tready;
    assign frame_end = pix_fire && last;
    assign pix       = img_input.tdata;

    assign ap_idle  = state == S_IDLE;
    assign ap_done  = state == S_DONE;
    assign ap_ready = state == S_DONE;

    assign out_ready = {cnn_output_4.tready, cnn_output_3.tready, cnn_output_2.tready,
                        cnn_output_1.tready, cnn_output_0.tready};
    assign out_fire  = out_valid & out_ready;

    assign cnn_output_0.tvalid = out_valid[OUT_AMP];
    assign cnn_output_1.tvalid = out_valid[OUT_ROW];
    assign cnn_output_2.tvalid = out_valid[OUT_COL];
    assign cnn_output_3.tvalid = out_valid[OUT_SUM];
    assign cnn_output_4.tvalid = out_valid[OUT_MIN];
    assign cnn_output_0.tdata  = out_data[OUT_AMP];
    assign cnn_output_1.tdata  = out_data[OUT_ROW];
    assign cnn_output_2.tdata  = out_data[OUT_COL];
    assign cnn_output_3.tdata  = out_data[OUT_SUM];
    assign cnn_output_4.tdata  = out_data[OUT_MIN];

    cpg_window_counter #(
        .IN_ROWS (IN_ROWS),
        .IN_COLS (IN_COLS),
        .OUT_ROWS(OUT_ROWS),
        .OUT_COLS(OUT_COLS)
    ) u_cnt (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .clr     (ap_idle),
        .adv     (pix_fire),
        .y1      (y1_q),
        .x1      (x1_q),
        .last    (last),
        .in_win  (in_win),
        .rel_row (rel_row),
        .rel_col (rel_col)
    );

    // Statistics including the pixel accepted this cycle, so the final pixel
    // is folded into the results latched on the STREAM->OUTPUT transition.
    // Max/min start at the opposite extreme with index (0,0); with strict
    // compares the first window pixel in raster order wins all ties.
    assign upd       = pix_fire && in_win;
    assign take_max  = upd && pix > max_q;
    assign take_min  = upd && pix < min_q;
    assign max_n     = take_max ? pix : max_q;
    assign max_row_n = take_max ? rel_row : max_row_q;
    assign max_col_n = take_max ? rel_col : max_col_q;
    assign min_n     = take_min ? pix : min_q;
    assign sum_n     = upd ? sum_q + {{(ACC_W-W){pix[W-1]}}, pix} : sum_q;
    assign sum_sh    = sum_n >>> SUM_SHIFT;

`ifdef CPG_SUM_SAT_EN
    assign sum_out = (sum_sh > SAT_HI) ? W'(SAT_HI) : (sum_sh < SAT_LO) ? W'(SAT_LO) : sum_sh[W-1:0];
`else
    assign sum_out = sum_sh[W-1:0];
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   state_n = ap_start ? S_COORD : S_IDLE;
            S_COORD:  state_n = ((y1_ok || y1_fire) && (x1_ok || x1_fire)) ? S_STREAM : S_COORD;
            S_STREAM: state_n = frame_end ? S_OUTPUT : S_STREAM;
            S_OUTPUT: state_n = ((out_valid & ~out_fire) == '0) ? S_DONE : S_OUTPUT;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst_n) begin
            state     <= S_IDLE;
            y1_ok     <= 1'b0;
            x1_ok     <= 1'b0;
            y1_q      <= '0;
            x1_q      <= '0;
            max_q     <= PIX_MIN;
            min_q     <= PIX_MAX;
            max_row_q <= '0;
            max_col_q <= '0;
            sum_q     <= '0;
            out_valid <= '0;
            out_data  <= '{default: '0};
        end else begin
            state <= state_n;
            if (ap_idle) begin
                y1_ok     <= 1'b0;
                x1_ok     <= 1'b0;
                max_q     <= PIX_MIN;
                min_q     <= PIX_MAX;
                max_row_q <= '0;
                max_col_q <= '0;
                sum_q     <= '0;
            end else begin
                max_q     <= max_n;
                min_q     <= min_n;
                max_row_q <= max_row_n;
                max_col_q <= max_col_n;
                sum_q     <= sum_n;
            end
            if (y1_fire) begin
                y1_ok <= 1'b1;
                y1_q  <= clamp_origin(CNT_W'(crop_Y1.tdata[IMG_ROW_BITWIDTH-1:0]), CNT_W'(IN_ROWS - OUT_ROWS));
            end
            if (x1_fire) begin
                x1_ok <= 1'b1;
                x1_q  <= clamp_origin(CNT_W'(crop_X1.tdata[IMG_COL_BITWIDTH-1:0]), CNT_W'(IN_COLS - OUT_COLS));
            end
            out_valid <= frame_end ? '1 : out_valid & ~out_fire;
            if (frame_end) begin
                out_data[OUT_AMP] <= max_n;
                out_data[OUT_ROW] <= W'(max_row_n);
                out_data[OUT_COL] <= W'(max_col_n);
                out_data[OUT_SUM] <= sum_out;
                out_data[OUT_MIN] <= min_n;
            end
        end
    end
endmodule

// File: tb/tb_crop_gaussian.sv
// tb_crop_gaussian: self-checking bench for crop_gaussian against a window-level reference model
module tb_crop_gaussian;
    localparam int IR = 100;
    localparam int IC = 160;
    localparam int OR = 48;
    localparam int OC = 48;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b1;
    logic ap_start = 1'b0;
    logic ap_done, ap_ready, ap_idle;

    crop_gaussian_if #(.W(16)) img ();
    crop_gaussian_if #(.W(10)) cy ();
    crop_gaussian_if #(.W(10)) cx ();
    crop_gaussian_if #(.W(16)) o0 ();
    crop_gaussian_if #(.W(16)) o1 ();
    crop_gaussian_if #(.W(16)) o2 ();
    crop_gaussian_if #(.W(16)) o3 ();
    crop_gaussian_if #(.W(16)) o4 ();

    crop_gaussian dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .img_input   (img),
        .crop_Y1     (cy),
        .crop_X1     (cx),
        .cnn_output_0(o0),
        .cnn_output_1(o1),
        .cnn_output_2(o2),
        .cnn_output_3(o3),
        .cnn_output_4(o4)
    );

    always #5 ap_clk = ~ap_clk;

    logic [4:0]  o_rdy = 5'h1f;
    logic [4:0]  o_vld;
    logic [15:0] o_dat [5];
    assign o0.tready = o_rdy[0];
    assign o1.tready = o_rdy[1];
    assign o2.tready = o_rdy[2];
    assign o3.tready = o_rdy[3];
    assign o4.tready = o_rdy[4];
    assign o_vld = {o4.tvalid, o3.tvalid, o2.tvalid, o1.tvalid, o0.tvalid};
    assign o_dat[0] = o0.tdata;
    assign o_dat[1] = o1.tdata;
    assign o_dat[2] = o2.tdata;
    assign o_dat[3] = o3.tdata;
    assign o_dat[4] = o4.tdata;

    int n_cmp = 0;
    int n_bad = 0;
    int beats [5] = '{default: 0};
    logic [15:0] got [5] = '{default: '0};
    int done_cnt = 0;
    int stab_bad = 0;
    bit hold [5] = '{default: 1'b0};
    logic [15:0] held [5] = '{default: '0};
    bit rdy_rand = 1'b0;
    int vcyc = 0;

    logic [15:0] exp_v [5];
    int b0 [5];
    int d0, s0, px_cycles;
    bit timeout, crop_rdy_early, crop_rdy_before;
    logic [4:0] vld_after_last;

    // Output consumer: always ready, or (random mode) held off for 1000 cycles
    // of pending output and then ready at random per channel.
    always @(posedge ap_clk) begin
        #1;
        vcyc = (o_vld == 5'h0) ? 0 : vcyc + 1;
        for (int k = 0; k < 5; k++) o_rdy[k] = !rdy_rand || (vcyc > 1000 && $urandom_range(0, 1) == 1);
    end

    // Monitor: counts beats and done pulses, and flags data changing while a beat is stalled.
    always @(negedge ap_clk) begin
        if (ap_done === 1'b1) done_cnt++;
        for (int k = 0; k < 5; k++) begin
            if (hold[k] && !ap_rst_n && (o_vld[k] !== 1'b1 || o_dat[k] !== held[k])) stab_bad++;
            hold[k] = !ap_rst_n && o_vld[k] && !o_rdy[k];
            held[k] = o_dat[k];
            if (o_vld[k] && o_rdy[k]) begin
                beats[k]++;
                got[k] = o_dat[k];
            end
        end
    end

    function automatic int pix(input int pat, input int r, input int c);
        return (pat == 0) ? 160 * r + c : (pat == 1) ? 100 : 32767;
    endfunction

    task automatic model(input int pat, input int y1, input int x1);
        int ys = (y1 > IR - OR) ? IR - OR : y1;
        int xs = (x1 > IC - OC) ? IC - OC : x1;
        int mx = pix(pat, ys, xs);
        int mn = mx;
        int mr = 0;
        int mc = 0;
        longint s = 0;
        for (int r = 0; r < OR; r++)
            for (int c = 0; c < OC; c++) begin
                int v = pix(pat, ys + r, xs + c);
                s += longint'(v);
                if (v > mx) begin mx = v; mr = r; mc = c; end
                if (v < mn) mn = v;
            end
        s = s >>> 11;
`ifdef CPG_SUM_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        exp_v[0] = 16'(mx);
        exp_v[1] = 16'(mr);
        exp_v[2] = 16'(mc);
        exp_v[3] = 16'(s);
        exp_v[4] = 16'(mn);
    endtask

    task automatic run_frame(input int pat, input int y1, input int x1, input bit rnd, input int abort_at, input bit poke_start);
        int i = 0;
        int guard = 0;
        bit fy, fx, fire;
        timeout = 1'b0;
        d0 = done_cnt;
        s0 = stab_bad;
        for (int k = 0; k < 5; k++) b0[k] = beats[k];
        crop_rdy_before = cy.tready || cx.tready;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        crop_rdy_early = cy.tready && cx.tready;
        cy.tdata = 10'(y1);
        cx.tdata = 10'(x1);
        cy.tvalid = 1'b1;
        cx.tvalid = 1'b1;
        while ((cy.tvalid || cx.tvalid) && guard < 100) begin
            @(negedge ap_clk);
            fy = cy.tvalid && cy.tready;
            fx = cx.tvalid && cx.tready;
            @(posedge ap_clk); #1;
            if (fy) cy.tvalid = 1'b0;
            if (fx) cx.tvalid = 1'b0;
            guard++;
        end
        if (cy.tvalid || cx.tvalid) timeout = 1'b1;
        cy.tvalid = 1'b0;
        cx.tvalid = 1'b0;
        guard = 0;
        while (i < IR * IC && guard < 40000) begin
            if (abort_at > 0 && i == abort_at) begin
                img.tvalid = 1'b0;
                ap_start = 1'b0;
                ap_rst_n = 1'b1;
                repeat (3) @(posedge ap_clk);
                #1;
                ap_rst_n = 1'b0;
                return;
            end
            ap_start = poke_start && i == 500;
            img.tvalid = !rnd || $urandom_range(0, 15) != 0;
            img.tdata = 16'(pix(pat, i / IC, i % IC));
            @(negedge ap_clk);
            fire = img.tvalid && img.tready;
            @(posedge ap_clk); #1;
            if (fire) i++;
            guard++;
        end
        px_cycles = guard;
        vld_after_last = o_vld;
        if (i < IR * IC) timeout = 1'b1;
        img.tvalid = 1'b0;
        ap_start = 1'b0;
        guard = 0;
        while (done_cnt == d0 && guard < 6000) begin
            @(posedge ap_clk); #1;
            guard++;
        end
        if (done_cnt == d0) timeout = 1'b1;
        repeat (4) @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        n_cmp++; if (ap_idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got=%b want=1", ap_idle); end
        n_cmp++; if ({ap_done, ap_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_done_ready got=%b want=00", {ap_done, ap_ready}); end
        n_cmp++; if (o_vld !== 5'h0) begin n_bad++; $display("FAIL reset_tvalid got=%b want=00000", o_vld); end
        n_cmp++; if ({img.tready, cy.tready, cx.tready} !== 3'b000) begin n_bad++; $display("FAIL reset_tready got=%b want=000", {img.tready, cy.tready, cx.tready}); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (o_dat[k] !== 16'h0) begin n_bad++; $display("FAIL reset_tdata%0d got=%h want=0000", k, o_dat[k]); end
        end
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_ramp;
        int plan [5] = '{9177, 47, 47, 6067, 1610};
        rdy_rand = 1'b0;
        run_frame(0, 10, 10, 1'b0, 0, 1'b0);
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL ramp_timeout got=%b want=0", timeout); end
        n_cmp++; if ({crop_rdy_before, crop_rdy_early} !== 2'b01) begin n_bad++; $display("FAIL ramp_crop_ready_latency got=%b want=01", {crop_rdy_before, crop_rdy_early}); end
        n_cmp++; if (px_cycles !== IR * IC) begin n_bad++; $display("FAIL ramp_throughput got=%0d want=%0d", px_cycles, IR * IC); end
        n_cmp++; if (vld_after_last !== 5'h1f) begin n_bad++; $display("FAIL ramp_tvalid_rise got=%b want=11111", vld_after_last); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL ramp_done_pulses got=%0d want=1", done_cnt - d0); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (beats[k] - b0[k] !== 1) begin n_bad++; $display("FAIL ramp_beats%0d got=%0d want=1", k, beats[k] - b0[k]); end
            n_cmp++; if (got[k] !== 16'(plan[k])) begin n_bad++; $display("FAIL ramp_out%0d got=%0d want=%0d", k, got[k], plan[k]); end
        end
    endtask

    task automatic test_const;
        int y1 = $urandom_range(0, 1023);
        int x1 = $urandom_range(0, 1023);
        model(1, y1, x1);
        run_frame(1, y1, x1, 1'b0, 0, 1'b0);
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL const_timeout got=%b want=0", timeout); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (got[k] !== exp_v[k]) begin n_bad++; $display("FAIL const_out%0d y1=%0d x1=%0d got=%0d want=%0d", k, y1, x1, got[k], exp_v[k]); end
        end
    endtask

    task automatic test_saturate;
        int y1 = $urandom_range(0, 1023);
        int x1 = $urandom_range(0, 1023);
        model(2, y1, x1);
        run_frame(2, y1, x1, 1'b0, 0, 1'b0);
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL sat_timeout got=%b want=0", timeout); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (got[k] !== exp_v[k]) begin n_bad++; $display("FAIL sat_out%0d got=%h want=%h", k, got[k], exp_v[k]); end
        end
    endtask

    task automatic test_stall;
        rdy_rand = 1'b1;
        model(0, 10, 10);
        run_frame(0, 10, 10, 1'b1, 0, 1'b0);
        rdy_rand = 1'b0;
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL stall_timeout got=%b want=0", timeout); end
        n_cmp++; if (stab_bad - s0 !== 0) begin n_bad++; $display("FAIL stall_data_stable got=%0d changes want=0", stab_bad - s0); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL stall_done_pulses got=%0d want=1", done_cnt - d0); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (beats[k] - b0[k] !== 1) begin n_bad++; $display("FAIL stall_beats%0d got=%0d want=1", k, beats[k] - b0[k]); end
            n_cmp++; if (got[k] !== exp_v[k]) begin n_bad++; $display("FAIL stall_out%0d got=%0d want=%0d", k, got[k], exp_v[k]); end
        end
    endtask

    task automatic test_abort_clamp;
        int plan [5] = '{15999, 47, 47, 0, 8432};
        int cut = $urandom_range(1000, 8000);
        rdy_rand = 1'b0;
        run_frame(0, 10, 10, 1'b0, cut, 1'b0);
        repeat (3) @(posedge ap_clk);
        #1;
        n_cmp++; if (ap_idle !== 1'b1) begin n_bad++; $display("FAIL abort_idle got=%b want=1", ap_idle); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL abort_done got=%0d want=0", done_cnt - d0); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (beats[k] - b0[k] !== 0) begin n_bad++; $display("FAIL abort_beats%0d got=%0d want=0", k, beats[k] - b0[k]); end
        end
        model(0, 80, 150);
        run_frame(0, 80, 150, 1'b0, 0, 1'b1);
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL clamp_timeout got=%b want=0", timeout); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL clamp_done_pulses got=%0d want=1", done_cnt - d0); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (beats[k] - b0[k] !== 1) begin n_bad++; $display("FAIL clamp_beats%0d got=%0d want=1", k, beats[k] - b0[k]); end
            n_cmp++; if (got[k] !== exp_v[k]) begin n_bad++; $display("FAIL clamp_out%0d got=%0d want=%0d", k, got[k], exp_v[k]); end
            if (k != 3) begin
                n_cmp++; if (got[k] !== 16'(plan[k])) begin n_bad++; $display("FAIL clamp_plan%0d got=%0d want=%0d", k, got[k], plan[k]); end
            end
        end
    endtask

    initial begin
        img.tvalid = 1'b0;
        img.tdata = '0;
        cy.tvalid = 1'b0;
        cy.tdata = '0;
        cx.tvalid = 1'b0;
        cx.tdata = '0;
        test_reset();
        test_ramp();
        test_const();
        test_saturate();
        test_stall();
        test_abort_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
